// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer catching a response while decode stalls the output slot.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_entry,
    output logic         o_valid
);

    fetch_entry_t r_entry;
    logic         r_valid;

    // Flush wins over push so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_entry <= i_entry;
            r_valid <= 1'b1;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_entry = r_entry;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect kill and decode skid.
// Optional macro FETCH_PERF_CNT_EN adds FetchCnt/KillCnt performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     MEM_LAT_MAX = 4
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic [XLEN-1:0] PC_In,
    input  logic            Redirect,
    output logic [XLEN-1:0] PCF,
    output logic            IReqValid,
    input  logic            IReqReady,
    output logic [XLEN-1:0] IReqAddr,
    input  logic            IRespValid,
    input  logic [XLEN-1:0] IRespData,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic            InstrValidD,
    input  logic            StallD,
    output logic            FetchTimeout
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     FetchCnt,
    output logic [31:0]     KillCnt
`endif
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT_MAX + 1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] r_req_pc;
    logic            r_ireq_valid;
    logic            r_pending;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pcd;
    logic            r_instr_valid;
    logic [LAT_W-1:0] r_lat_cnt;
    logic            r_timeout;

    logic            w_handshake;
    logic            w_resp_take;
    logic            w_slot_hold;
    logic            w_slot_load;
    logic            w_skid_push;
    logic            w_skid_pop;
    logic            w_skid_valid;
    logic            w_counting;
    fetch_entry_t    w_skid_in;
    fetch_entry_t    w_skid_out;

    assign w_skid_in = '{data: IRespData, pc: r_req_pc};

    fetch_skid_buf u_skid (
        .clk     (CPU_CLK),
        .rst_n   (CPU_RST_N),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_flush (Redirect),
        .i_entry (w_skid_in),
        .o_entry (w_skid_out),
        .o_valid (w_skid_valid)
    );

    // Handshake / response classification; responses during KILL or with a redirect are dropped.
    always_comb begin
        w_handshake = r_ireq_valid & IReqReady;
        w_resp_take = IRespValid & r_pending & (r_state == ST_WAIT) & ~Redirect;
        w_slot_hold = StallD & r_instr_valid;
        w_slot_load = ~Redirect & ~w_slot_hold & (w_skid_valid | w_resp_take);
        w_skid_push = w_resp_take & w_slot_hold;
        w_skid_pop  = ~Redirect & ~w_slot_hold & w_skid_valid;
        w_counting  = r_pending & ((r_state == ST_WAIT) | (r_state == ST_KILL));
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // WAIT also parks with nothing outstanding while the skid entry is full.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (w_handshake) begin
                    w_state_nxt = Redirect ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Redirect) begin
                    w_state_nxt = (r_pending & ~IRespValid) ? ST_KILL : ST_REQ;
                end else if (w_resp_take) begin
                    w_state_nxt = w_slot_hold ? ST_WAIT : ST_REQ;
                end else if (!r_pending && !w_skid_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_KILL: begin
                if (IRespValid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_pcf        <= RESET_PC;
            r_req_pc     <= '0;
            r_ireq_valid <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_ireq_valid <= (w_state_nxt == ST_REQ);
            if (Redirect || w_handshake) begin
                r_pcf <= PC_In;
            end
            if (w_handshake) begin
                r_pending <= 1'b1;
                r_req_pc  <= r_pcf;
            end else if (IRespValid) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Decode slot: skid entry is older than any fresh response, so it loads first.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_instr       <= '0;
            r_pcd         <= '0;
            r_instr_valid <= 1'b0;
        end else if (Redirect) begin
            r_instr_valid <= 1'b0;
        end else if (!w_slot_hold) begin
            r_instr_valid <= w_slot_load;
            if (w_skid_valid) begin
                r_instr <= w_skid_out.data;
                r_pcd   <= w_skid_out.pc;
            end else if (w_resp_take) begin
                r_instr <= IRespData;
                r_pcd   <= r_req_pc;
            end
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_lat_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (w_counting && !IRespValid) begin
            if (r_lat_cnt != LAT_W'(MEM_LAT_MAX)) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (r_lat_cnt >= LAT_W'(MEM_LAT_MAX - 1)) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_lat_cnt <= '0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_kill_cnt;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_fetch_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (w_slot_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (IRespValid && r_pending && !w_resp_take) begin
                r_kill_cnt <= r_kill_cnt + 32'd1;
            end
        end
    end

    assign FetchCnt = r_fetch_cnt;
    assign KillCnt  = r_kill_cnt;
`endif

    assign PCF          = r_pcf;
    assign IReqValid    = r_ireq_valid;
    assign IReqAddr     = r_pcf;
    assign InstrD       = r_instr;
    assign PCD          = r_pcd;
    assign InstrValidD  = r_instr_valid;
    assign FetchTimeout = r_timeout;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, timeout/reset sequence, random stream check.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N = 1'b1;
    logic [31:0] PC_In = '0;
    logic        Redirect = 1'b0;
    logic [31:0] PCF;
    logic        IReqValid;
    logic        IReqReady = 1'b0;
    logic [31:0] IReqAddr;
    logic        IRespValid = 1'b0;
    logic [31:0] IRespData = '0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        InstrValidD;
    logic        StallD = 1'b0;
    logic        FetchTimeout;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCnt;
    logic [31:0] KillCnt;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LAT_MAX(4)) dut (
        .CPU_CLK      (CPU_CLK),
        .CPU_RST_N    (CPU_RST_N),
        .PC_In        (PC_In),
        .Redirect     (Redirect),
        .PCF          (PCF),
        .IReqValid    (IReqValid),
        .IReqReady    (IReqReady),
        .IReqAddr     (IReqAddr),
        .IRespValid   (IRespValid),
        .IRespData    (IRespData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .InstrValidD  (InstrValidD),
        .StallD       (StallD),
        .FetchTimeout (FetchTimeout)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCnt     (FetchCnt),
        .KillCnt      (KillCnt)
`endif
    );

    always #5 CPU_CLK = ~CPU_CLK;

    typedef struct {
        logic        rdr;
        logic [31:0] pc_in;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic        stall;
        logic        e_irv;
        logic [31:0] e_pcf;
        logic        e_ivd;
        logic [31:0] e_instr;
        logic [31:0] e_pcd;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input bit ok, input string detail);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic add(input logic rdr, input logic [31:0] pc_in, input logic rdy,
                       input logic rsp, input logic [31:0] rdata, input logic stall,
                       input logic e_irv, input logic [31:0] e_pcf, input logic e_ivd,
                       input logic [31:0] e_instr, input logic [31:0] e_pcd);
        vec_t v;
        v = '{rdr, pc_in, rdy, rsp, rdata, stall, e_irv, e_pcf, e_ivd, e_instr, e_pcd};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rdr, input logic [31:0] pc_in, input logic rdy,
                         input logic rsp, input logic [31:0] rdata, input logic stall);
        Redirect   = rdr;
        PC_In      = pc_in;
        IReqReady  = rdy;
        IRespValid = rsp;
        IRespData  = rdata;
        StallD     = stall;
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        mem_busy;
        logic [31:0] mem_addr;
        int          mem_dly;
        int          n_cons;
        logic        rdr, rdy, rsp, stall;
        logic [31:0] rdata, pc_in;

        // Columns: redirect pc_in ready resp rdata stall | exp IReqValid PCF InstrValidD InstrD PCD
        add(0, 32'h4,   1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0);
        add(0, 32'h4,   1, 0, 32'h0,        0, 1, 32'h0,   0, 32'h0,        32'h0);
        add(0, 32'h8,   1, 1, 32'h13,       0, 0, 32'h4,   0, 32'h0,        32'h0);
        add(0, 32'h8,   1, 0, 32'h0,        0, 1, 32'h4,   1, 32'h13,       32'h0);
        add(0, 32'hC,   1, 1, 32'h00400093, 0, 0, 32'h8,   0, 32'h0,        32'h0);
        add(0, 32'hC,   1, 0, 32'h0,        0, 1, 32'h8,   1, 32'h00400093, 32'h4);
        add(1, 32'h100, 1, 0, 32'h0,        0, 0, 32'hC,   0, 32'h0,        32'h0);
        add(0, 32'h104, 1, 1, 32'hDEAD0008, 0, 0, 32'h100, 0, 32'h0,        32'h0);
        add(0, 32'h104, 1, 0, 32'h0,        0, 1, 32'h100, 0, 32'h0,        32'h0);
        add(0, 32'h108, 1, 1, 32'hA0000100, 0, 0, 32'h104, 0, 32'h0,        32'h0);
        add(1, 32'h10,  0, 0, 32'h0,        0, 1, 32'h104, 1, 32'hA0000100, 32'h100);
        add(0, 32'h14,  1, 0, 32'h0,        0, 1, 32'h10,  0, 32'h0,        32'h0);
        add(0, 32'h18,  1, 1, 32'h00001010, 1, 0, 32'h14,  0, 32'h0,        32'h0);
        add(0, 32'h18,  1, 0, 32'h0,        1, 1, 32'h14,  1, 32'h00001010, 32'h10);
        add(0, 32'h1C,  1, 1, 32'h00001414, 1, 0, 32'h18,  1, 32'h00001010, 32'h10);
        add(0, 32'h1C,  1, 0, 32'h0,        1, 0, 32'h18,  1, 32'h00001010, 32'h10);
        add(0, 32'h1C,  1, 0, 32'h0,        0, 0, 32'h18,  1, 32'h00001010, 32'h10);
        add(0, 32'h1C,  1, 0, 32'h0,        0, 0, 32'h18,  1, 32'h00001414, 32'h14);
        add(0, 32'h1C,  1, 0, 32'h0,        0, 1, 32'h18,  0, 32'h0,        32'h0);
        add(1, 32'h300, 1, 1, 32'hBAD00018, 0, 0, 32'h1C,  0, 32'h0,        32'h0);
        add(0, 32'h304, 0, 0, 32'h0,        0, 1, 32'h300, 0, 32'h0,        32'h0);
        add(1, 32'h200, 0, 0, 32'h0,        0, 1, 32'h300, 0, 32'h0,        32'h0);
        add(0, 32'h204, 1, 0, 32'h0,        0, 1, 32'h200, 0, 32'h0,        32'h0);
        add(0, 32'h208, 1, 1, 32'h20000293, 0, 0, 32'h204, 0, 32'h0,        32'h0);
        add(0, 32'h208, 0, 0, 32'h0,        0, 1, 32'h204, 1, 32'h20000293, 32'h200);
        add(1, 32'h400, 1, 0, 32'h0,        0, 1, 32'h204, 0, 32'h0,        32'h0);
        add(0, 32'h404, 1, 1, 32'hBAD00204, 0, 0, 32'h400, 0, 32'h0,        32'h0);
        add(0, 32'h404, 1, 0, 32'h0,        0, 1, 32'h400, 0, 32'h0,        32'h0);
        add(0, 32'h408, 1, 1, 32'h40000013, 0, 0, 32'h404, 0, 32'h0,        32'h0);
        add(1, 32'hFFFFFFFC, 0, 0, 32'h0,   0, 1, 32'h404, 1, 32'h40000013, 32'h400);
        add(0, 32'h0,   1, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h0,   32'h0);
        add(0, 32'h4,   1, 1, 32'hFFFF0013, 0, 0, 32'h0,   0, 32'h0,        32'h0);
        add(0, 32'h4,   0, 0, 32'h0,        0, 1, 32'h0,   1, 32'hFFFF0013, 32'hFFFFFFFC);

        // Reset values while reset is held
        #1 CPU_RST_N = 1'b0;
        repeat (2) @(negedge CPU_CLK);
        check("reset_vals",
              PCF === 32'h0 && IReqValid === 1'b0 && InstrValidD === 1'b0 &&
              InstrD === 32'h0 && PCD === 32'h0 && FetchTimeout === 1'b0,
              $sformatf("got pcf=%h irv=%b ivd=%b instr=%h pcd=%h to=%b want all zero",
                        PCF, IReqValid, InstrValidD, InstrD, PCD, FetchTimeout));
        @(posedge CPU_CLK);
        #2 CPU_RST_N = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CPU_CLK);
            ok = (IReqValid === vecs[i].e_irv) && (PCF === vecs[i].e_pcf) &&
                 (IReqAddr === vecs[i].e_pcf) && (InstrValidD === vecs[i].e_ivd) &&
                 (FetchTimeout === 1'b0);
            if (vecs[i].e_ivd) begin
                ok = ok && (InstrD === vecs[i].e_instr) && (PCD === vecs[i].e_pcd);
            end
            check($sformatf("vec%0d", i), ok,
                  $sformatf("got irv=%b pcf=%h addr=%h ivd=%b instr=%h pcd=%h to=%b want irv=%b pcf=%h ivd=%b instr=%h pcd=%h",
                            IReqValid, PCF, IReqAddr, InstrValidD, InstrD, PCD, FetchTimeout,
                            vecs[i].e_irv, vecs[i].e_pcf, vecs[i].e_ivd, vecs[i].e_instr, vecs[i].e_pcd));
            drive(vecs[i].rdr, vecs[i].pc_in, vecs[i].rdy, vecs[i].rsp, vecs[i].rdata, vecs[i].stall);
        end

        // Timeout: request at PCF 0, response withheld for 4 wait cycles
        @(negedge CPU_CLK);
        drive(0, 32'h4, 1, 0, 32'h0, 0);
        @(negedge CPU_CLK);
        drive(0, 32'h8, 0, 0, 32'h0, 0);
        repeat (3) @(negedge CPU_CLK);
        check("timeout_early", FetchTimeout === 1'b0,
              $sformatf("got to=%b want 0 after 3 wait cycles", FetchTimeout));
        @(negedge CPU_CLK);
        check("timeout_set", FetchTimeout === 1'b1,
              $sformatf("got to=%b want 1 after 4 wait cycles", FetchTimeout));
        drive(0, 32'h8, 0, 1, 32'h33, 0);
        @(negedge CPU_CLK);
        drive(0, 32'h8, 0, 0, 32'h0, 1);
        check("timeout_sticky",
              FetchTimeout === 1'b1 && InstrValidD === 1'b1 && InstrD === 32'h33 && PCD === 32'h0,
              $sformatf("got to=%b ivd=%b instr=%h pcd=%h want to=1 ivd=1 instr=00000033 pcd=00000000",
                        FetchTimeout, InstrValidD, InstrD, PCD));
        repeat (2) @(negedge CPU_CLK);
        check("timeout_hold", FetchTimeout === 1'b1 && PCF === 32'h4,
              $sformatf("got to=%b pcf=%h want to=1 pcf=00000004", FetchTimeout, PCF));
        #2 CPU_RST_N = 1'b0;
        #1;
        check("async_reset",
              FetchTimeout === 1'b0 && PCF === 32'h0 && IReqValid === 1'b0 && InstrValidD === 1'b0,
              $sformatf("got to=%b pcf=%h irv=%b ivd=%b want to=0 pcf=00000000 irv=0 ivd=0",
                        FetchTimeout, PCF, IReqValid, InstrValidD));
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge CPU_CLK);
        #2 CPU_RST_N = 1'b1;

        // Random traffic against a sequential-stream model with a single-slot memory
        exp_pc   = 32'h0;
        mem_busy = 1'b0;
        mem_addr = '0;
        mem_dly  = 0;
        n_cons   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CPU_CLK);
            rsp   = 1'b0;
            rdata = '0;
            if (mem_busy) begin
                if (mem_dly == 0) begin
                    rsp      = 1'b1;
                    rdata    = imem(mem_addr);
                    mem_busy = 1'b0;
                end else begin
                    mem_dly--;
                end
            end
            rdr = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 16383)) << 2);
            pc_in = rdr ? tgt : PCF + 32'd4;
            rdy   = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 3) == 0);
            if (IReqValid && rdy) begin
                check("one_outstanding", !mem_busy && !rsp,
                      $sformatf("got new request at %h while busy=%b resp=%b want none outstanding",
                                IReqAddr, mem_busy, rsp));
                mem_busy = 1'b1;
                mem_addr = IReqAddr;
                mem_dly  = $urandom_range(0, 2);
            end
            if (InstrValidD && !stall && !rdr) begin
                check("stream", PCD === exp_pc && InstrD === imem(exp_pc),
                      $sformatf("got pcd=%h instr=%h want pcd=%h instr=%h",
                                PCD, InstrD, exp_pc, imem(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            if (rdr) begin
                exp_pc = tgt;
            end
            drive(rdr, pc_in, rdy, rsp, rdata, stall);
        end
        @(negedge CPU_CLK);
        check("progress", n_cons > 200,
              $sformatf("got %0d instructions consumed want more than 200", n_cons));
        check("no_timeout_random", FetchTimeout === 1'b0,
              $sformatf("got to=%b want 0 with short memory latency", FetchTimeout));
`ifdef FETCH_PERF_CNT_EN
        $display("perf: FetchCnt=%0d KillCnt=%0d", FetchCnt, KillCnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
